axi_sub_responder: RTL

//  AXI subordinate endpoint: accepts single-beat writes (AW+W, answers B) and reads (AR, answers R)

---
 rtl/axi_pkg.sv | 28 ++
 rtl/axi_sub_mem_array.sv | 46 ++++
 rtl/axi_sub_responder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the subordinate responder and anything that
// decodes its new_data vector.
//  - resp_t   : AXI response codes carried on BRESP/RRESP
//  - CH_*     : bit positions of each channel inside the 5-bit new_data /
//               tx_en style vectors ([4]AW [3]W [2]B [1]AR [0]R)
//  - range_resp : maps an address range check onto the response code
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  localparam int CH_AW = 4;
  localparam int CH_W  = 3;
  localparam int CH_B  = 2;
  localparam int CH_AR = 1;
  localparam int CH_R  = 0;

  // In-range accesses complete normally; anything beyond the array is a
  // subordinate error (the decode itself always succeeds, so never DECERR).
  function automatic resp_t range_resp(input logic in_range);
    return in_range ? OKAY : SLVERR;
  endfunction

endpackage

// File: rtl/axi_sub_mem_array.sv
// Word-addressed storage behind the AXI subordinate responder.
// Ports:
//  clk, rst : clock and asynchronous active-high clear (all words -> 0)
//  we       : commit a write this edge
//  waddr    : word index of the write
//  wdata    : write data, only lanes with wstrb set are updated
//  wstrb    : byte enables, one per 8-bit lane of wdata
//  raddr    : word index of the read
//  rdata    : combinational read data (returns the pre-write value on the
//             edge a write to the same word commits)
module axi_sub_mem_array
  import axi_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [IDX_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wstrb[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_sub_responder.sv
// AXI subordinate endpoint serving single-beat writes (AW+W -> B) and
// reads (AR -> R) out of an internal word-addressed memory.
// Ports:
//  ACLK, ARESET             : clock, asynchronous active-high reset
//  AWADDR/AWVALID/AWREADY   : write address channel
//  WDATA/WSTRB/WVALID/WREADY: write data channel
//  BRESP/BVALID/BREADY      : write response channel
//  ARADDR/ARVALID/ARREADY   : read address channel
//  RDATA/RRESP/RVALID/RREADY: read data channel
//  new_data                 : one-cycle pulse per channel handshake,
//                             [4]AW [3]W [2]B [1]AR [0]R
//  dbg_state                : {write FSM in WR_RESP, read FSM in RD_DATA}
//
// Handshake semantics (all channels): a beat transfers on the rising edge
// where VALID and READY are both high. A source holds VALID and its payload
// stable until that edge. READY outputs here are functions of local state
// only (never of a VALID input) and are forced low while ARESET is high.
module axi_sub_responder
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [4:0]          new_data,
  output logic [1:0]          dbg_state
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t         wr_state;
  rd_state_t         rd_state;

  // AW and W are captured independently; a hold flag marks a captured beat
  // still waiting for its partner.
  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [LANES-1:0]  w_strb_q;

  logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic wr_commit;

  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [LANES-1:0]  wr_strb;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic              wr_in_range;
  logic              rd_in_range;
  logic [DATA_W-1:0] mem_rdata;

  assign AWREADY = !ARESET && (wr_state == WR_IDLE) && !aw_held;
  assign WREADY  = !ARESET && (wr_state == WR_IDLE) && !w_held;
  assign ARREADY = !ARESET && (rd_state == RD_IDLE);

  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;
  assign b_fire  = BVALID && BREADY;
  assign ar_fire = ARVALID && ARREADY;
  assign r_fire  = RVALID && RREADY;

  // The beat that completes the pair may arrive this very edge, so take
  // the live bus value for whichever half is not yet held.
  assign wr_addr = aw_held ? aw_addr_q : AWADDR;
  assign wr_data = w_held ? w_data_q : WDATA;
  assign wr_strb = w_held ? w_strb_q : WSTRB;

  assign wr_commit = (wr_state == WR_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);

  // Byte offset bits are dropped; the full upper index is range checked so
  // aliases beyond DEPTH never reach the array.
  assign wr_idx      = wr_addr >> OFF_W;
  assign rd_idx      = ARADDR >> OFF_W;
  assign wr_in_range = wr_idx < ADDR_W'(DEPTH);
  assign rd_in_range = rd_idx < ADDR_W'(DEPTH);

  axi_sub_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (ACLK),
    .rst   (ARESET),
    .we    (wr_commit && wr_in_range),
    .waddr (wr_idx[IDX_W-1:0]),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .raddr (rd_idx[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  // Write FSM
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state  <= WR_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      BVALID    <= 1'b0;
      BRESP     <= OKAY;
    end else if (wr_state == WR_IDLE) begin
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= AWADDR;
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (wr_commit) begin
        BVALID   <= 1'b1;
        BRESP    <= range_resp(wr_in_range);
        wr_state <= WR_RESP;
      end
    end else begin
      // Holds stay set through WR_RESP and release with the response.
      if (b_fire) begin
        BVALID   <= 1'b0;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        wr_state <= WR_IDLE;
      end
    end
  end

  // Read FSM; the array read is combinational so a write committing on the
  // same edge is not yet visible (read-before-write).
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state <= RD_IDLE;
      RVALID   <= 1'b0;
      RDATA    <= '0;
      RRESP    <= OKAY;
    end else if (rd_state == RD_IDLE) begin
      if (ar_fire) begin
        RVALID   <= 1'b1;
        RDATA    <= rd_in_range ? mem_rdata : '0;
        RRESP    <= range_resp(rd_in_range);
        rd_state <= RD_DATA;
      end
    end else begin
      if (r_fire) begin
        RVALID   <= 1'b0;
        rd_state <= RD_IDLE;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      new_data <= '0;
    end else begin
      new_data[CH_AW] <= aw_fire;
      new_data[CH_W]  <= w_fire;
      new_data[CH_B]  <= b_fire;
      new_data[CH_AR] <= ar_fire;
      new_data[CH_R]  <= r_fire;
    end
  end

  assign dbg_state = {wr_state == WR_RESP, rd_state == RD_DATA};

endmodule
